// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types and helpers for the serialising priority encoder.
// Holds the two-state FSM encoding and the index-width derivation.
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width of an index into an n-bit request vector (n is 2..64, so never 0).
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational priority finder over a request vector.
// Reports the winning index (highest or lowest set bit per MSB_PRIO),
// whether any bit is set, and whether exactly one bit is set.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter int N        = 8,
  parameter int MSB_PRIO = 1,
  localparam int W       = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any,
  output logic         o_one
);

  // Scan order makes the last hit the winner: ascending for MSB priority,
  // descending for LSB priority. Index is 0 when nothing is set.
  always_comb begin
    o_idx = '0;
    if (MSB_PRIO != 0) begin
      for (int i = 0; i < N; i++) begin
        if (i_req[i]) o_idx = i[W-1:0];
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = i[W-1:0];
      end
    end
    o_any = |i_req;
    o_one = o_any && ((i_req & (i_req - N'(1))) == '0);
  end

endmodule

// File: rtl/prio_encoder_ser.sv
// prio_encoder_ser: accepts a multi-hot request vector and emits the index of
// every set bit, one beat per cycle, in priority order (valid/ready on both
// sides). An all-zero vector produces a single "none" beat.
// Optional feature: define PRIO_ENC_FLUSH_EN to add a flush input that aborts
// the vector being emitted.
module prio_encoder_ser
  import prio_enc_pkg::*;
#(
  parameter int N        = 8,
  parameter int MSB_PRIO = 1,
  localparam int W       = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PRIO_ENC_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  state_t       r_state;
  logic [N-1:0] r_mask;
  logic         r_out_valid;

  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_one;
  logic         w_flush;
  logic         w_hs;
  logic         w_last_hs;
  logic         w_accept;
  logic [N-1:0] w_clr;

`ifdef PRIO_ENC_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  prio_find #(
    .N       (N),
    .MSB_PRIO(MSB_PRIO)
  ) u_find (
    .i_req(r_mask),
    .o_idx(w_idx),
    .o_any(w_any),
    .o_one(w_one)
  );

  // Beat fields follow the residual mask; they cannot change while a beat is
  // stalled because the mask only moves on a handshake. An empty mask while
  // valid can only be the single beat of an all-zero vector.
  assign out_valid = r_out_valid;
  assign out_idx   = w_idx;
  assign out_last  = r_out_valid & (w_one | ~w_any);
  assign out_none  = r_out_valid & ~w_any;

  assign w_hs      = r_out_valid & out_ready;
  assign w_last_hs = w_hs & out_last;
  assign w_clr     = N'(1) << w_idx;

  // A new vector is taken when idle, or when the last beat leaves this cycle.
  assign in_ready  = ~rst & ~w_flush & ((r_state == IDLE) | w_last_hs);
  assign w_accept  = in_valid & in_ready;

  // FSM and residual mask: reset, then flush, then accept, then beat retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_flush && (r_state == EMIT)) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= EMIT;
      r_mask      <= in_req;
      r_out_valid <= 1'b1;
    end else if (w_last_hs) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_hs) begin
      r_mask      <= r_mask & ~w_clr;
    end
  end

endmodule

// File: tb/tb_prio_encoder_ser.sv
// tb_prio_encoder_ser: directed vectors into two encoders (MSB and LSB
// priority) sharing one stimulus; expected beats are queued per vector and a
// negedge monitor checks every presented beat against the queue head.
module tb_prio_encoder_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_req;
`ifdef PRIO_ENC_FLUSH_EN
  logic       flush = 1'b0;
`endif

  logic       ir_h, ov_h, ol_h, on_h;
  logic [2:0] oi_h;
  logic       ir_l, ov_l, ol_l, on_l;
  logic [2:0] oi_l;

  prio_encoder_ser #(.N(8), .MSB_PRIO(1)) u_hi (
    .clk(clk), .rst(rst),
`ifdef PRIO_ENC_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(ir_h), .in_req(in_req),
    .out_valid(ov_h), .out_ready(out_ready), .out_idx(oi_h),
    .out_last(ol_h), .out_none(on_h)
  );

  prio_encoder_ser #(.N(8), .MSB_PRIO(0)) u_lo (
    .clk(clk), .rst(rst),
`ifdef PRIO_ENC_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(ir_l), .in_req(in_req),
    .out_valid(ov_l), .out_ready(out_ready), .out_idx(oi_l),
    .out_last(ol_l), .out_none(on_l)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  beat_t q_hi[$];
  beat_t q_lo[$];
  beat_t e_h, e_l;
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic beat_t mk(input int idx, input bit last, input bit none);
    beat_t b;
    b.idx  = idx[2:0];
    b.last = last;
    b.none = none;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each presented beat must match the head of its queue; a stalled
  // beat is compared without popping, so it must stay stable while held.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ov_h === 1'b1) begin
        if (q_hi.size() == 0) begin
          check("hi_unexpected_beat", 32'({oi_h, ol_h, on_h}), 32'hFFFF);
        end else begin
          e_h = q_hi[0];
          check("hi_beat", 32'({oi_h, ol_h, on_h}), 32'(e_h));
          if (out_ready) void'(q_hi.pop_front());
        end
      end
      if (ov_l === 1'b1) begin
        if (q_lo.size() == 0) begin
          check("lo_unexpected_beat", 32'({oi_l, ol_l, on_l}), 32'hFFFF);
        end else begin
          e_l = q_lo[0];
          check("lo_beat", 32'({oi_l, ol_l, on_l}), 32'(e_l));
          if (out_ready) void'(q_lo.pop_front());
        end
      end
    end
  end

  // Offer one vector, then drain it. out_ready is held low for the first
  // 'hold' beat cycles; k beats must then take exactly k+hold cycles.
  task automatic send(input logic [7:0] req, input int k, input int hold,
                      input logic ir_first);
    int g;
    int cnt;
    n_vec++;
    in_req   = req;
    in_valid = 1'b1;
    g = 0;
    while (ir_h !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("accept_ready", 32'(ir_h), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_req   = 8'h00;
    out_ready = (hold == 0);
    #1;
    check("in_ready_first_beat", 32'(ir_h), 32'(ir_first));
    check("out_valid_latency1", 32'(ov_h), 32'd1);
    cnt = 0;
    while (q_hi.size() != 0 && cnt < 40) begin
      out_ready = (cnt >= hold);
      @(posedge clk); #1;
      cnt++;
    end
    check("beat_cycles", 32'(cnt), 32'(k + hold));
    check("lo_queue_drained", 32'(q_lo.size()), 32'd0);
    check("idle_after_vector", 32'(ov_h), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_req    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'({ov_h, ov_l}), 32'd0);
    check("rst_in_ready", 32'({ir_h, ir_l}), 32'd0);
    check("rst_beat_fields", 32'({oi_h, ol_h, on_h}), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'({ir_h, ir_l}), 32'b11);

    // Single bit 0: one last beat, in_ready high during it.
    q_hi.push_back(mk(0, 1, 0));
    q_lo.push_back(mk(0, 1, 0));
    send(8'b0000_0001, 1, 0, 1'b1);

    // Bits 7 and 5: MSB order 7,5; LSB order 5,7.
    q_hi.push_back(mk(7, 0, 0)); q_hi.push_back(mk(5, 1, 0));
    q_lo.push_back(mk(5, 0, 0)); q_lo.push_back(mk(7, 1, 0));
    send(8'b1010_0000, 2, 0, 1'b0);

    // All-zero vector: single none beat.
    q_hi.push_back(mk(0, 1, 1));
    q_lo.push_back(mk(0, 1, 1));
    send(8'h00, 1, 0, 1'b1);

    // Bits 7 and 2 with 3 stall cycles on the first beat.
    q_hi.push_back(mk(7, 0, 0)); q_hi.push_back(mk(2, 1, 0));
    q_lo.push_back(mk(2, 0, 0)); q_lo.push_back(mk(7, 1, 0));
    send(8'b1000_0100, 2, 3, 1'b0);

    // All ones, reset after two beats.
    n_vec++;
    q_hi.push_back(mk(7, 0, 0)); q_hi.push_back(mk(6, 0, 0));
    q_lo.push_back(mk(0, 0, 0)); q_lo.push_back(mk(1, 0, 0));
    in_req    = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_req   = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("two_beats_taken_hi", 32'(q_hi.size()), 32'd0);
    check("two_beats_taken_lo", 32'(q_lo.size()), 32'd0);
    check("third_beat_hi", 32'({ov_h, oi_h}), 32'({1'b1, 3'd5}));
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_out_valid", 32'({ov_h, ov_l}), 32'd0);
    check("rst_mid_in_ready", 32'(ir_h), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_mid_rst", 32'(ir_h), 32'd1);
    @(posedge clk); #1;
    check("no_beat_after_rst", 32'({ov_h, ov_l}), 32'd0);

    // Next vector after reset, bits 4 and 1.
    q_hi.push_back(mk(4, 0, 0)); q_hi.push_back(mk(1, 1, 0));
    q_lo.push_back(mk(1, 0, 0)); q_lo.push_back(mk(4, 1, 0));
    send(8'b0001_0010, 2, 0, 1'b0);

    // Three bits with one stall, MSB 6,3,0 / LSB 0,3,6.
    q_hi.push_back(mk(6, 0, 0)); q_hi.push_back(mk(3, 0, 0)); q_hi.push_back(mk(0, 1, 0));
    q_lo.push_back(mk(0, 0, 0)); q_lo.push_back(mk(3, 0, 0)); q_lo.push_back(mk(6, 1, 0));
    send(8'b0100_1001, 3, 1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("final_hi_queue", 32'(q_hi.size()), 32'd0);
    check("final_lo_queue", 32'(q_lo.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
